// File: rtl/ffd_pkg.sv
// Shared defaults and helpers for the ffd_pipe delay/alignment element.
package ffd_pkg;

  localparam int unsigned FFD_WIDTH_DEF = 8;
  localparam int unsigned FFD_DEPTH_DEF = 3;
  localparam int unsigned FFD_SYNC_DEF  = 2;

  // Width of a counter holding 0..depth; never narrower than one bit.
  function automatic int unsigned ffd_level_w(input int unsigned depth);
    if (depth <= 1) return 1;
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assertion, release after SYNC_STAGES clock edges.
module rst_sync
  import ffd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = FFD_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic rst_done
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_done = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ffd_pipe.sv
// Clock-enabled register pipeline with per-stage valid bits, occupancy count
// and a built-in reset-release synchroniser.
module ffd_pipe
  import ffd_pkg::*;
#(
  parameter int unsigned      WIDTH       = FFD_WIDTH_DEF,
  parameter int unsigned      DEPTH       = FFD_DEPTH_DEF,
  parameter int unsigned      SYNC_STAGES = FFD_SYNC_DEF,
  parameter bit               DATA_RST    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  output logic [ffd_level_w(DEPTH)-1:0]     level,
  output logic                              rst_done
);

  localparam int unsigned LVL_W = ffd_level_w(DEPTH);

  logic                         rst_s;
  logic [DEPTH-1:0]             valid_w;
  logic [DEPTH-1:0][WIDTH-1:0]  data_w;
  logic [LVL_W-1:0]             level_q;
  logic [LVL_W-1:0]             level_d;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_done (rst_done)
  );

  assign rst_s = ~rst_done;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (i == 0) begin : g_head
      assign v_in = in_valid;
      assign d_in = in_data;
    end else begin : g_link
      assign v_in = valid_w[i-1];
      assign d_in = data_w[i-1];
    end

    // Valid bits always reset; bubbles travel as valid=0 entries.
    always_ff @(posedge clk or posedge rst_s) begin
      if (rst_s)    v_q <= 1'b0;
      else if (clr) v_q <= 1'b0;
      else if (ce)  v_q <= v_in;
    end

    if (DATA_RST) begin : g_data_rst
      always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s)    d_q <= RST_VAL;
        else if (clr) d_q <= RST_VAL;
        else if (ce)  d_q <= d_in;
      end
    end else begin : g_data_nrst
      // No reset on data: hold while in reset or on clear.
      always_ff @(posedge clk) begin
        if (!rst_s && !clr && ce) d_q <= d_in;
      end
    end

    assign valid_w[i] = v_q;
    assign data_w[i]  = d_q;
  end

  // Occupancy tracks entries in minus entries out, so it matches the valid popcount.
  always_comb begin
    level_d = level_q;
    if (clr)     level_d = '0;
    else if (ce) level_d = level_q + LVL_W'(in_valid) - LVL_W'(out_valid);
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) level_q <= '0;
    else       level_q <= level_d;
  end

  assign out_valid = valid_w[DEPTH-1];
  assign out_data  = data_w[DEPTH-1];
  assign level     = level_q;

endmodule
